// File: rtl/inv_subbytes_if.sv
// Start/busy/done handshake and data bus of the inverse SubBytes engine.
// The master drives a state block; the slave returns its substitution.
interface inv_subbytes_if;
    logic         start;
    logic [127:0] beforeInvSub;
    logic         busy;
    logic         done;
    logic [127:0] afterInvSub;

    modport master (
        output start, beforeInvSub,
        input  busy, done, afterInvSub
    );

    modport slave (
        input  start, beforeInvSub,
        output busy, done, afterInvSub
    );
endinterface

// File: rtl/inv_subbytes.sv
// Inverse AES SubBytes: LANES bytes per cycle through shared inverse S-boxes.
// Byte 0 sits in bits [127:120]; chunk c covers bytes c*LANES onwards.
module inv_subbytes #(
    parameter int LANES = 4
) (
    input logic          i_clk,
    input logic          i_rst_n,
    inv_subbytes_if.slave bus
);
    localparam int N  = 16 / LANES;
    localparam int W  = LANES * 8;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [127:0]  r_src;
    logic [127:0]  r_work;
    logic [127:0]  r_out;
    logic          r_busy;
    logic          r_done;

    logic [31:0]   w_sh;
    logic [127:0]  w_src_sh;
    logic [W-1:0]  w_chunk;
    logic [W-1:0]  w_sub;
    logic [127:0]  w_ins;
    logic [127:0]  w_mask;
    logic [127:0]  w_next;
    logic          w_last;

    // Shifting the current chunk to the top keeps the lane slicing static.
    assign w_sh     = 32'(r_cnt) * 32'(W);
    assign w_src_sh = r_src << w_sh;
    assign w_chunk  = w_src_sh[127 -: W];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_sub[W-1-8*g -: 8] = INV_SBOX[w_chunk[W-1-8*g -: 8]];
    end

    assign w_ins  = (128'(w_sub) << (128 - W)) >> w_sh;
    assign w_mask = ({128{1'b1}} << (128 - W)) >> w_sh;
    assign w_next = (r_work & ~w_mask) | w_ins;
    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_src   <= '0;
            r_work  <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_src   <= bus.beforeInvSub;
                        r_work  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_work <= w_next;
                    if (w_last) begin
                        r_out   <= w_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.afterInvSub = r_out;
endmodule

// File: tb/tb_inv_subbytes.sv
// Directed bench for inv_subbytes: table extremes, round trips, handshake,
// async reset and a LANES sweep over five instances sharing one stimulus.
module tb_inv_subbytes;
    localparam logic [7:0] FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] din;
    int           checks;
    int           failures;

    inv_subbytes_if if1 ();
    inv_subbytes_if if2 ();
    inv_subbytes_if if4 ();
    inv_subbytes_if if8 ();
    inv_subbytes_if if16 ();

    assign if1.start  = start;
    assign if2.start  = start;
    assign if4.start  = start;
    assign if8.start  = start;
    assign if16.start = start;
    assign if1.beforeInvSub  = din;
    assign if2.beforeInvSub  = din;
    assign if4.beforeInvSub  = din;
    assign if8.beforeInvSub  = din;
    assign if16.beforeInvSub = din;

    inv_subbytes #(.LANES(1))  u_l1  (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
    inv_subbytes #(.LANES(2))  u_l2  (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
    inv_subbytes #(.LANES(4))  u_l4  (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));
    inv_subbytes #(.LANES(8))  u_l8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if8));
    inv_subbytes #(.LANES(16)) u_l16 (.i_clk(clk), .i_rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fwd128(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = FWD[x[127-8*i -: 8]];
        return r;
    endfunction

    // Pulse start for one edge on the LANES=4 instance and wait for done.
    task automatic run4(input logic [127:0] d, output logic [127:0] res, output int lat);
        din   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!if4.done && lat < 40) begin
            tick();
            lat++;
        end
        if (!if4.done) lat = 0;
        res = if4.afterInvSub;
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] x;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] xs [4];
        logic [127:0] rs [5];
        int           lat;
        int           n;
        int           k;
        int           ls [5];

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        din      = '0;

        repeat (3) tick();
        chk("rst_busy", 128'(if4.busy), 128'd0);
        chk("rst_done", 128'(if4.done), 128'd0);
        chk("rst_out", if4.afterInvSub, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        din   = {16{8'h63}};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("acc_busy", 128'(if4.busy), 128'd1);
        chk("acc_done", 128'(if4.done), 128'd0);
        lat = 1;
        while (!if4.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("lat63", 128'(lat), 128'd5);
        chk("res63", if4.afterInvSub, 128'h0);
        chk("done_busy", 128'(if4.busy), 128'd0);
        tick();
        chk("done_pulse", 128'(if4.done), 128'd0);
        chk("hold63", if4.afterInvSub, 128'h0);

        run4(128'h0, res, lat);
        chk("res00", res, {16{8'h52}});
        run4(128'h16d77c63_00000000_00000000_00000000, res, lat);
        chk("resext", res, 128'hff0d0100_52525252_52525252_52525252);

        for (int i = 0; i < 10; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            run4(fwd128(x), res, lat);
            chk("roundtrip", res, x);
        end

        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) begin
                a[127-8*i -: 8] = FWD[16*blk + i];
                b[127-8*i -: 8] = 8'(16*blk + i);
            end
            run4(a, res, lat);
            chk("sweep_tbl", res, b);
        end

        // Start re-asserted with new data during a run must be ignored.
        x     = 128'h0123456789abcdeffedcba9876543210;
        din   = fwd128(x);
        start = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i < 2);
            if (i < 2) din = fwd128(128'h00112233445566778899aabbccddeeff);
            tick();
            if (if4.done) begin
                n++;
                res = if4.afterInvSub;
            end
        end
        start = 1'b0;
        chk("ign_pulses", 128'(n), 128'd1);
        chk("ign_res", res, x);

        xs[0] = 128'h00000000000000000000000000000001;
        xs[1] = 128'hdeadbeefcafef00d0badc0de12345678;
        xs[2] = 128'hffffffffffffffffffffffffffffffff;
        xs[3] = 128'h8899aabbccddeeff0011223344556677;
        din   = fwd128(xs[0]);
        start = 1'b1;
        k     = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (if4.done) begin
                if (k < 4) begin
                    chk("b2b_res", if4.afterInvSub, xs[k]);
                    chk("b2b_cyc", 128'(cyc), 128'(5 * (k + 1)));
                end
                k++;
                if (k < 4) din = fwd128(xs[k]);
            end
        end
        start = 1'b0;
        chk("b2b_count", 128'(k), 128'd4);

        din   = fwd128(128'h0123456789abcdeffedcba9876543210);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(if4.busy), 128'd0);
        chk("arst_done", 128'(if4.done), 128'd0);
        chk("arst_out", if4.afterInvSub, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        x = 128'h00112233445566778899aabbccddeeff;
        run4(fwd128(x), res, lat);
        chk("arst_lat", 128'(lat), 128'd5);
        chk("arst_res", res, x);
        repeat (20) tick();

        din   = 128'h16d77c63_00000000_00000000_00000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ls[i] = 0;
            rs[i] = '0;
        end
        for (int e = 2; e <= 25; e++) begin
            tick();
            if (if1.done  && ls[0] == 0) begin ls[0] = e; rs[0] = if1.afterInvSub;  end
            if (if2.done  && ls[1] == 0) begin ls[1] = e; rs[1] = if2.afterInvSub;  end
            if (if4.done  && ls[2] == 0) begin ls[2] = e; rs[2] = if4.afterInvSub;  end
            if (if8.done  && ls[3] == 0) begin ls[3] = e; rs[3] = if8.afterInvSub;  end
            if (if16.done && ls[4] == 0) begin ls[4] = e; rs[4] = if16.afterInvSub; end
        end
        chk("lat_l1",  128'(ls[0]), 128'd17);
        chk("lat_l2",  128'(ls[1]), 128'd9);
        chk("lat_l4",  128'(ls[2]), 128'd5);
        chk("lat_l8",  128'(ls[3]), 128'd3);
        chk("lat_l16", 128'(ls[4]), 128'd2);
        for (int i = 0; i < 5; i++)
            chk("res_lanes", rs[i], 128'hff0d0100_52525252_52525252_52525252);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
